// File: rtl/priv_1_12_trap_seq.sv
// -----------------------------------------------------------------------------
// priv_1_12_trap_seq
//
// Trap/return sequencer sitting directly in front of the priv 1.12 CSR file.
// Arbitrates pending M-mode interrupts, synchronous exceptions and MRET, drains
// the pipeline through a flush handshake, issues a single-cycle commit pulse
// carrying the mcause/mepc/mtval write data, then redirects fetch to the mtvec
// target (trap) or to mepc (MRET). Only one event is in flight at a time.
//
// Parameters
//   VECTORED_EN    1: interrupts honour mtvec.mode==VECTORED; 0: always DIRECT
//
// Ports
//   CLK, nRST      clock; asynchronous active-low reset
//   ex_valid/ex_cause/ex_epc/ex_tval   synchronous exception from pipeline
//   int_pend       {meip,mtip,msip} already masked by mie
//   mstatus_mie    global machine interrupt enable
//   int_epc        return point for an interrupt
//   mret_req       MRET reached commit
//   mtvec_base/mtvec_mode              trap vector (sampled in COMMIT)
//   csr_mepc       current mepc, MRET target (sampled in COMMIT)
//   flush_req/flush_ack                pipeline drain handshake
//   trap_commit/mret_commit            one-cycle CSR update strobes
//   mcause_wdata/mepc_wdata/mtval_wdata CSR write data, valid with the strobe
//   redirect_valid/redirect_ready/redirect_pc  fetch redirect handshake
//   busy           sequencer is not idle
// -----------------------------------------------------------------------------
module priv_1_12_trap_seq #(
   parameter bit VECTORED_EN = 1'b1
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ex_valid,
   input  logic [3:0]  ex_cause,
   input  logic [31:0] ex_epc,
   input  logic [31:0] ex_tval,
   input  logic [2:0]  int_pend,
   input  logic        mstatus_mie,
   input  logic [31:0] int_epc,
   input  logic        mret_req,
   input  logic [29:0] mtvec_base,
   input  logic [1:0]  mtvec_mode,
   input  logic [31:0] csr_mepc,
   output logic        flush_req,
   input  logic        flush_ack,
   output logic        trap_commit,
   output logic        mret_commit,
   output logic [31:0] mcause_wdata,
   output logic [31:0] mepc_wdata,
   output logic [31:0] mtval_wdata,
   output logic        redirect_valid,
   input  logic        redirect_ready,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLUSH    = 2'd1,
      COMMIT   = 2'd2,
      REDIRECT = 2'd3
   } state_t;

   state_t state, next_state;

   // Event captured at acceptance
   logic        lat_is_int;
   logic        lat_is_mret;
   logic [3:0]  lat_code;
   logic [31:0] lat_epc;
   logic [31:0] lat_tval;
   logic [31:0] redirect_pc_r;

   logic        int_eligible;
   logic [3:0]  int_code;
   logic        accept;
   logic [31:0] trap_base;
   logic [31:0] trap_target;
   logic [31:0] mret_target;
   logic        use_vector;

   assign int_eligible = mstatus_mie & (|int_pend);
   assign accept       = (state == IDLE) & (int_eligible | ex_valid | mret_req);

   // Fixed interrupt priority: MEI > MSI > MTI
   always_comb begin
      int_code = 4'd0;
      if (int_pend[2])      int_code = 4'd11;
      else if (int_pend[0]) int_code = 4'd3;
      else if (int_pend[1]) int_code = 4'd7;
   end

   // Only mode 1 vectors; reserved modes 2/3 fall back to DIRECT
   assign use_vector  = VECTORED_EN & lat_is_int & (mtvec_mode == 2'd1);
   assign trap_base   = {mtvec_base, 2'b00};
   assign trap_target = use_vector ? (trap_base + {26'd0, lat_code, 2'b00}) : trap_base;
   assign mret_target = csr_mepc & 32'hFFFF_FFFC;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state     = state;
      flush_req      = 1'b0;
      trap_commit    = 1'b0;
      mret_commit    = 1'b0;
      redirect_valid = 1'b0;
      busy           = (state != IDLE);
      case (state)
         IDLE: begin
            if (accept) next_state = FLUSH;
         end
         FLUSH: begin
            flush_req = 1'b1;
            if (flush_ack) next_state = COMMIT;
         end
         COMMIT: begin
            trap_commit = ~lat_is_mret;
            mret_commit = lat_is_mret;
            next_state  = REDIRECT;
         end
         REDIRECT: begin
            redirect_valid = 1'b1;
            if (redirect_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Event capture in the accepting IDLE cycle; redirect target in COMMIT
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         lat_is_int    <= 1'b0;
         lat_is_mret   <= 1'b0;
         lat_code      <= 4'd0;
         lat_epc       <= 32'd0;
         lat_tval      <= 32'd0;
         redirect_pc_r <= 32'd0;
      end else begin
         if (accept) begin
            if (int_eligible) begin
               lat_is_int  <= 1'b1;
               lat_is_mret <= 1'b0;
               lat_code    <= int_code;
               lat_epc     <= int_epc & 32'hFFFF_FFFC;
               lat_tval    <= 32'd0;
            end else if (ex_valid) begin
               lat_is_int  <= 1'b0;
               lat_is_mret <= 1'b0;
               lat_code    <= ex_cause;
               lat_epc     <= ex_epc & 32'hFFFF_FFFC;
               lat_tval    <= ex_tval;
            end else begin
               lat_is_int  <= 1'b0;
               lat_is_mret <= 1'b1;
               lat_code    <= 4'd0;
               lat_epc     <= 32'd0;
               lat_tval    <= 32'd0;
            end
         end
         if (state == COMMIT) begin
            redirect_pc_r <= lat_is_mret ? mret_target : trap_target;
         end
      end
   end

   assign mcause_wdata = {lat_is_int, 27'd0, lat_code};
   assign mepc_wdata   = lat_epc;
   assign mtval_wdata  = lat_tval;
   assign redirect_pc  = redirect_pc_r;

endmodule
